// File: rtl/bp_be_fpu_issue_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bp_be_fpu_issue_sched                                        |
// | Description : Round-robin, credit-gated issue scheduler for a shared       |
// |               fixed-latency FPU pipe. A shadow pipe carries each op's      |
// |               source id and tag alongside the FPU, and results land in a  |
// |               small registered result FIFO.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bp_be_fpu_issue_sched #(
  parameter int latency_p     = 5,
  parameter int tag_width_p   = 5,
  parameter int fifo_els_p    = 4,
  parameter int dword_width_p = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 req_v_i,
  input  logic [2*tag_width_p-1:0]   req_tag_i,
  output logic [1:0]                 req_ready_o,
  input  logic                       flush_i,
  output logic                       fpu_v_o,
  output logic                       fpu_src_o,
  input  logic [dword_width_p-1:0]   fpu_data_i,
  input  logic [4:0]                 fpu_eflags_i,
  output logic                       res_v_o,
  output logic                       res_src_o,
  output logic [tag_width_p-1:0]     res_tag_o,
  output logic [dword_width_p-1:0]   res_data_o,
  output logic [4:0]                 res_eflags_o,
  input  logic                       res_yumi_i
);

  localparam int CNT_W = $clog2(fifo_els_p + 1);
  localparam int PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(fifo_els_p);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(fifo_els_p - 1);

  // Credits, arbitration pointer and FIFO bookkeeping
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             last_q, last_d;

  // Shadow pipe: valid bits are reset, payload is not
  logic [latency_p-1:0]   sh_v_q;
  logic [latency_p-1:0]   sh_src_q;
  logic [tag_width_p-1:0] sh_tag_q [latency_p];

  // FIFO storage
  logic                     mem_src_q  [fifo_els_p];
  logic [tag_width_p-1:0]   mem_tag_q  [fifo_els_p];
  logic [dword_width_p-1:0] mem_data_q [fifo_els_p];
  logic [4:0]               mem_ef_q   [fifo_els_p];

  logic                   w_sel, w_issue, w_push, w_pop;
  logic [tag_width_p-1:0] w_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Arbitration: contention goes to the requester that did not win last time;
  // reset_i is folded in so the grant drops asynchronously with reset.
  always_comb begin
    w_sel       = (&req_v_i) ? ~last_q : req_v_i[1];
    w_issue     = (|req_v_i) & (cnt_q < c_full_cnt) & ~flush_i & ~reset_i;
    w_tag       = w_sel ? req_tag_i[tag_width_p +: tag_width_p] : req_tag_i[0 +: tag_width_p];
    req_ready_o = w_issue ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
    fpu_v_o     = w_issue;
    fpu_src_o   = w_issue & w_sel;
  end

  // Result side: push when the last shadow stage is live; flush kills both ends
  always_comb begin
    w_push       = sh_v_q[latency_p-1] & ~flush_i;
    res_v_o      = (fill_q != '0);
    w_pop        = res_yumi_i & res_v_o & ~flush_i;
    res_src_o    = mem_src_q[rptr_q];
    res_tag_o    = mem_tag_q[rptr_q];
    res_data_o   = mem_data_q[rptr_q];
    res_eflags_o = mem_ef_q[rptr_q];
  end

  // Next-state for credits, pointers, occupancy and round-robin pointer
  always_comb begin
    cnt_d  = cnt_q;
    fill_d = fill_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = w_issue ? w_sel : last_q;
    if (w_issue && !w_pop)      cnt_d = cnt_q + 1'b1;
    else if (!w_issue && w_pop) cnt_d = cnt_q - 1'b1;
    if (w_push && !w_pop)       fill_d = fill_q + 1'b1;
    else if (!w_push && w_pop)  fill_d = fill_q - 1'b1;
    if (w_push) wptr_d = ptr_inc(wptr_q);
    if (w_pop)  rptr_d = ptr_inc(rptr_q);
    if (flush_i) begin
      cnt_d  = '0;
      fill_d = '0;
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      fill_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= 1'b1;
      sh_v_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fill_q <= fill_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
      if (flush_i) begin
        sh_v_q <= '0;
      end else begin
        sh_v_q[0] <= w_issue;
        for (int i = 1; i < latency_p; i++) sh_v_q[i] <= sh_v_q[i-1];
      end
    end
  end

  // Shadow-pipe payload advances every cycle in lockstep with the FPU
  always_ff @(posedge clk_i) begin
    sh_src_q[0] <= w_sel;
    sh_tag_q[0] <= w_tag;
    for (int i = 1; i < latency_p; i++) begin
      sh_src_q[i] <= sh_src_q[i-1];
      sh_tag_q[i] <= sh_tag_q[i-1];
    end
  end

  // FIFO write port: capture the FPU result with its shadow id/tag
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_src_q[wptr_q]  <= sh_src_q[latency_p-1];
      mem_tag_q[wptr_q]  <= sh_tag_q[latency_p-1];
      mem_data_q[wptr_q] <= fpu_data_i;
      mem_ef_q[wptr_q]   <= fpu_eflags_i;
    end
  end

`ifndef SYNTHESIS
  // Credits must make overflow impossible
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(w_push && (fill_q == c_full_cnt) && !w_pop))
    else $error("result FIFO overflow");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fpu_issue_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bp_be_fpu_issue_sched                                     |
// | Description : Directed, table-driven bench for bp_be_fpu_issue_sched       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bp_be_fpu_issue_sched;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_v_i;
  logic [9:0]  req_tag_i;
  logic [1:0]  req_ready_o;
  logic        flush_i;
  logic        fpu_v_o;
  logic        fpu_src_o;
  logic [63:0] fpu_data_i;
  logic [4:0]  fpu_eflags_i;
  logic        res_v_o;
  logic        res_src_o;
  logic [4:0]  res_tag_o;
  logic [63:0] res_data_o;
  logic [4:0]  res_eflags_o;
  logic        res_yumi_i;

  int cyc;
  int checks;
  int errors;

  bp_be_fpu_issue_sched dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_v_i      (req_v_i),
    .req_tag_i    (req_tag_i),
    .req_ready_o  (req_ready_o),
    .flush_i      (flush_i),
    .fpu_v_o      (fpu_v_o),
    .fpu_src_o    (fpu_src_o),
    .fpu_data_i   (fpu_data_i),
    .fpu_eflags_i (fpu_eflags_i),
    .res_v_o      (res_v_o),
    .res_src_o    (res_src_o),
    .res_tag_o    (res_tag_o),
    .res_data_o   (res_data_o),
    .res_eflags_o (res_eflags_o),
    .res_yumi_i   (res_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // The FPU model returns a value unique to the cycle it is sampled in
  function automatic logic [63:0] exp_data(input int c);
    return {32'hC0DE_0000, 32'(c)};
  endfunction
  function automatic logic [4:0] exp_ef(input int c);
    return 5'(c) ^ 5'h15;
  endfunction

  always_comb begin
    fpu_data_i   = exp_data(cyc);
    fpu_eflags_i = exp_ef(cyc);
  end

  typedef struct {
    logic [1:0] v;
    logic [4:0] t0;
    logic [4:0] t1;
    logic       yumi;
    logic [1:0] e_rdy;
    logic       e_rv;
    logic       e_src;
    logic [4:0] e_tag;
    int         e_dcyc;
  } vec_t;

  vec_t vq[$];

  task automatic row(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                     input logic y, input logic [1:0] rdy, input logic rv,
                     input logic src, input logic [4:0] tag, input int dc);
    vec_t r;
    r.v = v; r.t0 = t0; r.t1 = t1; r.yumi = y; r.e_rdy = rdy;
    r.e_rv = rv; r.e_src = src; r.e_tag = tag; r.e_dcyc = dc;
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_issue(input logic [1:0] rdy);
    chk("req_ready", 64'(req_ready_o), 64'(rdy));
    chk("fpu_v", 64'(fpu_v_o), 64'(|rdy));
    chk("fpu_src", 64'(fpu_src_o), 64'(rdy == 2'b10));
  endtask

  task automatic chk_res(input logic rv, input logic src, input logic [4:0] tag, input int dc);
    chk("res_v", 64'(res_v_o), 64'(rv));
    if (rv) begin
      chk("res_src", 64'(res_src_o), 64'(src));
      chk("res_tag", 64'(res_tag_o), 64'(tag));
      chk("res_data", res_data_o, exp_data(dc));
      chk("res_eflags", 64'(res_eflags_o), 64'(exp_ef(dc)));
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1,
                       input logic y, input logic fl);
    req_v_i    = v;
    req_tag_i  = {t1, t0};
    res_yumi_i = y;
    flush_i    = fl;
    #1;
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset_i = 1'b1;
    apply(2'b11, 5'h1, 5'h2, 1'b0, 1'b0);
    chk_issue(2'b00);
    chk_res(1'b0, 1'b0, 5'h0, 0);
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cyc = 0;

    // Single op, contention, credit exhaustion and full-plus-dequeue
    row(2'b01, 5'h03, 5'h00, 0, 2'b01, 0, 0, 5'h00, 0);   // c0
    for (int i = 1; i <= 5; i++) row(2'b00, 5'h0, 5'h0, 0, 2'b00, 0, 0, 5'h0, 0);
    row(2'b11, 5'h0A, 5'h0B, 1, 2'b10, 1, 0, 5'h03, 5);   // c6
    row(2'b11, 5'h0A, 5'h0B, 0, 2'b01, 0, 0, 5'h00, 0);   // c7
    row(2'b11, 5'h0A, 5'h0B, 0, 2'b10, 0, 0, 5'h00, 0);   // c8
    row(2'b11, 5'h0A, 5'h0B, 0, 2'b01, 0, 0, 5'h00, 0);   // c9
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 0, 0, 5'h00, 0);   // c10
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 0, 0, 5'h00, 0);   // c11
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 1, 1, 5'h0B, 11);  // c12
    row(2'b01, 5'h05, 5'h00, 0, 2'b00, 1, 1, 5'h0B, 11);  // c13
    row(2'b01, 5'h05, 5'h00, 0, 2'b00, 1, 1, 5'h0B, 11);  // c14
    row(2'b01, 5'h05, 5'h00, 0, 2'b00, 1, 1, 5'h0B, 11);  // c15
    row(2'b01, 5'h07, 5'h00, 1, 2'b00, 1, 1, 5'h0B, 11);  // c16 full + dequeue
    row(2'b01, 5'h07, 5'h00, 0, 2'b01, 1, 0, 5'h0A, 12);  // c17 issue resumes
    row(2'b01, 5'h07, 5'h00, 1, 2'b00, 1, 0, 5'h0A, 12);  // c18 full again
    row(2'b00, 5'h00, 5'h00, 1, 2'b00, 1, 1, 5'h0B, 13);  // c19
    row(2'b00, 5'h00, 5'h00, 1, 2'b00, 1, 0, 5'h0A, 14);  // c20
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 0, 0, 5'h00, 0);   // c21
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 0, 0, 5'h00, 0);   // c22
    row(2'b00, 5'h00, 5'h00, 1, 2'b00, 1, 0, 5'h07, 22);  // c23
    row(2'b00, 5'h00, 5'h00, 0, 2'b00, 0, 0, 5'h00, 0);   // c24

    foreach (vq[i]) begin
      apply(vq[i].v, vq[i].t0, vq[i].t1, vq[i].yumi, 1'b0);
      chk_issue(vq[i].e_rdy);
      chk_res(vq[i].e_rv, vq[i].e_src, vq[i].e_tag, vq[i].e_dcyc);
      adv();
    end

    // Flush with one entry buffered and two ops in flight (cyc 25..)
    apply(2'b01, 5'h11, 5'h0, 0, 0); chk_issue(2'b01); adv();          // c25
    for (int i = 0; i < 5; i++) begin apply(2'b00, 5'h0, 5'h0, 0, 0); adv(); end
    apply(2'b01, 5'h12, 5'h0, 0, 0);                                    // c31
    chk_res(1'b1, 1'b0, 5'h11, 30); chk_issue(2'b01); adv();
    apply(2'b01, 5'h13, 5'h0, 0, 0); chk_issue(2'b01); adv();          // c32
    apply(2'b01, 5'h14, 5'h0, 1, 1); chk_issue(2'b00); adv();          // c33 flush
    apply(2'b01, 5'h15, 5'h0, 0, 0);                                    // c34
    chk_res(1'b0, 1'b0, 5'h0, 0); chk_issue(2'b01); adv();
    for (int i = 0; i < 5; i++) begin                                   // c35..c39
      apply(2'b00, 5'h0, 5'h0, 0, 0); chk_res(1'b0, 1'b0, 5'h0, 0); adv();
    end
    apply(2'b00, 5'h0, 5'h0, 1, 0); chk_res(1'b1, 1'b0, 5'h15, 39); adv(); // c40

    // Backpressure: exactly four credits after the flush (cyc 41..)
    for (int i = 0; i < 6; i++) begin
      apply(2'b01, 5'(5'h18 + i), 5'h0, 0, 0);
      chk_issue(i < 4 ? 2'b01 : 2'b00);
      adv();
    end
    for (int i = 0; i < 3; i++) begin apply(2'b00, 5'h0, 5'h0, 0, 0); adv(); end  // c47..c49
    for (int i = 0; i < 4; i++) begin                                   // c50..c53
      apply(2'b00, 5'h0, 5'h0, 1, 0);
      chk_res(1'b1, 1'b0, 5'(5'h18 + i), 46 + i);
      adv();
    end
    apply(2'b00, 5'h0, 5'h0, 0, 0); chk_res(1'b0, 1'b0, 5'h0, 0);     // c54

    // Reset mid-flight: one result buffered, two ops in the pipe
    apply(2'b01, 5'h1C, 5'h0, 0, 0); adv();                             // c54 issue
    for (int i = 0; i < 5; i++) begin apply(2'b00, 5'h0, 5'h0, 0, 0); adv(); end
    apply(2'b01, 5'h1D, 5'h0, 0, 0); chk_res(1'b1, 1'b0, 5'h1C, 59); adv(); // c60
    apply(2'b01, 5'h1E, 5'h0, 0, 0); chk_issue(2'b01); adv();          // c61
    apply(2'b11, 5'h01, 5'h02, 0, 0); chk_issue(2'b10);                 // c62
    #2 reset_i = 1'b1;
    #1;
    chk_issue(2'b00);
    chk("res_v_async", 64'(res_v_o), 64'd0);
    adv(); adv();
    reset_i = 1'b0;                                                     // c64
    apply(2'b11, 5'h06, 5'h09, 0, 0); chk_issue(2'b01); adv();
    for (int i = 0; i < 5; i++) begin                                   // c65..c69
      apply(2'b00, 5'h0, 5'h0, 0, 0); chk_res(1'b0, 1'b0, 5'h0, 0); adv();
    end
    apply(2'b00, 5'h0, 5'h0, 1, 0); chk_res(1'b1, 1'b0, 5'h06, 69); adv(); // c70
    apply(2'b00, 5'h0, 5'h0, 0, 0); chk_res(1'b0, 1'b0, 5'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
